// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter: NUM_REQ requesters share one synchronous FIFO write port.
// Each grant costs one arbitration cycle. A burst ends on req_last or after MAX_BURST beats.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_cs,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  // state | meaning
  // IDLE  | no owner; any valid request is arbitrated on the next edge
  // BURST | grant_id owns the write port until req_last or the beat limit

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   rr_win;
  logic              rr_found;
  logic              burst_end;
  int                rr_idx;

  // first valid requester at or after last_id+1, wrapping
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_id) + k) % NUM_REQ;
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = ID_W'(rr_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST && !fifo_full)
      req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en = req_valid[grant_id] & req_ready[grant_id];
  assign fifo_cs    = fifo_wr_en;
  assign fifo_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign burst_end  = req_last[grant_id] | (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      last_id     <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (rr_found) begin
            state       <= BURST;
            grant_valid <= 1'b1;
            grant_id    <= rr_win;
            beat_cnt    <= '0;
          end
        end
        BURST: begin
          // a stalled or empty owner simply holds the grant
          if (fifo_wr_en) begin
            if (burst_end) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              last_id     <= grant_id;
              beat_cnt    <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a
// transaction-level model (owner index, beats taken, per-requester word sequence).
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            fifo_full;
  logic            fifo_cs;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  fifo_wr_arb #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int seq [NREQ];
  int m_owner;
  int m_beats;
  int m_last;

  int grants[$];
  int lens[$];
  int cur_len;
  int stalls;
  bit prev_gv;

  function automatic logic [DW-1:0] word_of(int i, int s);
    return {i[7:0], s[23:0]};
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      req_data[i*DW +: DW] = word_of(i, seq[i]);
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NREQ - 1;
    prev_gv = 1'b0;
    cur_len = 0;
  endtask

  function automatic int qget(int q[$], int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    bit exp_wr;
    int acc;
    #1;
    exp_ready = (m_owner >= 0 && !fifo_full) ? NREQ'(1 << m_owner) : '0;
    exp_wr    = (m_owner >= 0) && !fifo_full && req_valid[m_owner];
    check("req_ready",   req_ready,   exp_ready);
    check("fifo_wr_en",  fifo_wr_en,  exp_wr);
    check("fifo_cs",     fifo_cs,     exp_wr);
    check("grant_valid", grant_valid, (m_owner >= 0));
    if (m_owner >= 0) check("grant_id", grant_id, m_owner);
    if (exp_wr) check("fifo_data", fifo_data, word_of(m_owner, seq[m_owner]));

    if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
    if (!grant_valid && prev_gv) begin
      lens.push_back(cur_len);
      cur_len = 0;
    end
    if (fifo_wr_en) cur_len++;
    if (grant_valid && fifo_full) stalls++;
    prev_gv = grant_valid;

    acc = -1;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && req_valid[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ;
          m_beats = 0;
        end
      end
    end else if (exp_wr) begin
      acc = m_owner;
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    @(posedge clk);
    if (acc >= 0) seq[acc]++;
    @(negedge clk);
  endtask

  // finish any open grant with single-beat bursts, then idle a cycle
  task automatic drain();
    for (int n = 0; n < 20 && m_owner >= 0; n++) begin
      req_valid = NREQ'(1 << m_owner);
      req_last  = '1;
      fifo_full = 1'b0;
      step();
    end
    req_valid = '0;
    req_last  = '0;
    step();
  endtask

  task automatic clear_log();
    grants.delete();
    lens.delete();
    stalls = 0;
  endtask

  initial begin
    int s0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    rst = 1'b1;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    model_reset();
    clear_log();
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id",    grant_id,    0);
    check("rst_req_ready",   req_ready,   0);
    check("rst_fifo_wr_en",  fifo_wr_en,  0);
    @(negedge clk);
    rst = 1'b0;

    // all requesters, single-beat bursts
    req_valid = '1;
    req_last  = '1;
    for (int n = 0; n < 30 && grants.size() < 5; n++) step();
    check("rr_done", grants.size() >= 5, 1);
    check("rr_g0", qget(grants, 0), 0);
    check("rr_g1", qget(grants, 1), 1);
    check("rr_g2", qget(grants, 2), 2);
    check("rr_g3", qget(grants, 3), 3);
    check("rr_g4", qget(grants, 4), 0);
    for (int i = 0; i < 4; i++) check("rr_len", qget(lens, i), 1);
    drain();

    // 12-beat burst from req 2, truncated at MAX_BURST
    clear_log();
    s0 = seq[2];
    for (int n = 0; n < 40 && lens.size() < 2; n++) begin
      req_valid = (seq[2] - s0 < 12) ? 4'b0100 : 4'b0000;
      req_last  = {1'b0, (seq[2] - s0 == 11), 2'b00};
      step();
    end
    check("trunc_done", lens.size() >= 2, 1);
    check("trunc_len0", qget(lens, 0), 8);
    check("trunc_len1", qget(lens, 1), 4);
    check("trunc_g0",   qget(grants, 0), 2);
    check("trunc_g1",   qget(grants, 1), 2);
    drain();

    // req 1 burst of 6, FIFO full for 3 cycles after 2 beats
    clear_log();
    s0 = seq[1];
    for (int n = 0; n < 40 && lens.size() < 1; n++) begin
      req_valid = (seq[1] - s0 < 6) ? 4'b0010 : 4'b0000;
      req_last  = {2'b00, (seq[1] - s0 == 5), 1'b0};
      fifo_full = (seq[1] - s0 == 2) && (stalls < 3);
      step();
    end
    fifo_full = 1'b0;
    check("full_done",   lens.size() >= 1, 1);
    check("full_len",    qget(lens, 0), 6);
    check("full_stalls", stalls, 3);
    check("full_g0",     qget(grants, 0), 1);
    drain();

    // req 0 arrives while req 3 holds a 5-beat burst
    clear_log();
    s0 = seq[3];
    for (int n = 0; n < 40 && grants.size() < 2; n++) begin
      req_valid = {(seq[3] - s0 < 5), 2'b00, (seq[3] - s0 >= 2)};
      req_last  = {(seq[3] - s0 == 4), 3'b000};
      step();
    end
    check("pre_done", grants.size() >= 2, 1);
    check("pre_g0",   qget(grants, 0), 3);
    check("pre_g1",   qget(grants, 1), 0);
    check("pre_len0", qget(lens, 0), 5);
    drain();

    // reset in the middle of a req 1 burst
    clear_log();
    s0 = seq[1];
    req_valid = 4'b0010;
    req_last  = '0;
    for (int n = 0; n < 20 && !(m_owner == 1 && m_beats == 3); n++) step();
    check("mid_reached", (m_owner == 1 && m_beats == 3), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gv",    grant_valid, 0);
    check("mid_rst_ready", req_ready,   0);
    check("mid_rst_wr",    fifo_wr_en,  0);
    check("mid_rst_cs",    fifo_cs,     0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    req_valid = 4'b0011;
    for (int n = 0; n < 10 && grants.size() < 1; n++) step();
    check("mid_regrant", qget(grants, 0), 0);
    drain();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_last[i]  = ($urandom_range(0, 3) == 0);
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      step();
    end
    fifo_full = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, maximum beats per grant (1..256).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, bit i = requester i presents a word.
REQ-007 The block SHALL have port req_last, input, NUM_REQ, bit i = requester i's current word ends its burst.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i's word in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, bit i = requester i's word is accepted this cycle.
REQ-010 The block SHALL have port fifo_full, input, 1, full flag from the downstream synchronous FIFO.
REQ-011 The block SHALL have port fifo_cs, output, 1, FIFO chip select.
REQ-012 The block SHALL have port fifo_wr_en, output, 1, FIFO write enable.
REQ-013 The block SHALL have port fifo_data, output, DATA_WIDTH, FIFO write data.
REQ-014 The block SHALL have port grant_valid, output, 1, a requester currently owns the FIFO write port.
REQ-015 The block SHALL have port grant_id, output, $clog2(NUM_REQ), index of the owning requester.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE with any req_valid bit high, the next edge SHALL register the winner into grant_id, set grant_valid=1, clear beat_cnt and enter BURST; there is one arbitration cycle with no transfer.
REQ-018 The winner SHALL be chosen round-robin: the first requester with valid high, searching from (last_id+1) mod NUM_REQ upward with wrap-around.
REQ-019 In IDLE with no req_valid, the FSM SHALL stay in IDLE and leave last_id unchanged.
REQ-020 req_ready[i] SHALL be combinational: state==BURST AND grant_id==i AND !fifo_full; all other bits 0.
REQ-021 fifo_wr_en SHALL equal req_valid[grant_id] AND req_ready[grant_id]; fifo_cs SHALL equal fifo_wr_en; fifo_data SHALL be req_data of grant_id, combinational, so the FIFO captures the word on the same edge.
REQ-022 While fifo_full=1, no beat SHALL transfer, and grant and beat_cnt SHALL hold.
REQ-023 beat_cnt SHALL increment on each transfer and saturate-free count 0..MAX_BURST-1.
REQ-024 A transfer with req_last=1, or a transfer when beat_cnt==MAX_BURST-1, SHALL end the grant: next state IDLE, grant_valid=0, last_id<=grant_id.
REQ-025 If req_last and the MAX_BURST limit coincide, the block SHALL end the grant once, with no extra beat.
REQ-026 A requester truncated by MAX_BURST SHALL re-arbitrate for the rest of its burst and receive no priority over others.
REQ-027 If the owner deasserts req_valid mid-burst, the block SHALL hold the grant; no timeout.
REQ-028 req_valid/req_data/req_last of non-granted requesters SHALL have no effect on outputs.

Reset
REQ-029 On rst=1, immediately and asynchronously: state=IDLE, grant_valid=0, grant_id=0, beat_cnt=0, last_id=NUM_REQ-1 (requester 0 wins first); req_ready, fifo_wr_en, fifo_cs =0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no write on that edge; after release, arbitration restarts from requester 0.

Verification
REQ-031 Reset, then req_valid=4'b1111 continuously with req_last=1 every beat -> grants 0,1,2,3,0 in that order, each with 1 arbitration cycle + 1 transfer.
REQ-032 Only req 2 valid, 12 beats, req_last on beat 12, MAX_BURST=8 -> 8 transfers, 1 IDLE cycle, re-grant to 2, 4 transfers, then grant_valid=0.
REQ-033 Req 1 in BURST, fifo_full=1 for 3 cycles mid-burst -> req_ready=0 and fifo_wr_en=0 for exactly those 3 cycles, beat_cnt frozen, data order at FIFO preserved.
REQ-034 Req 3 bursting, req 0 raises valid -> req 0 not granted until req 3's req_last transfer; req 0 granted on the following IDLE cycle.
REQ-035 rst pulsed while req 1 at beat 3 -> outputs zero in the same cycle; after release with 4'b0011 valid, req 0 granted first.
REQ-036 Scoreboard over random valid/last/full traffic -> every accepted word written exactly once, per-requester order kept, no write while fifo_full=1.
